// File: rtl/iomem_tone_pkg.sv
// Shared definitions for the iomem tone bank: register offsets, CTRL/STATUS
// bit positions and the byte-lane merge used by every writable register.
// Optional duration logic elsewhere is controlled by macro TONE_DURATION_EN.
package iomem_tone_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_HALF   = 2'd1,
      REG_STATUS = 2'd2,
      REG_DUR    = 2'd3
   } reg_e;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_POL      = 1;
   localparam int CTRL_DONE_CLR = 2;

   localparam int STAT_TONE = 0;
   localparam int STAT_RUN  = 1;
   localparam int STAT_DONE = 2;

   // Replace only the byte lanes whose strobe is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
      logic [31:0] r;
      r = old_val;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/iomem_tone_bank_if.sv
// PicoSoC iomem request/response bundle between the CPU bus and the tone bank.
// The master holds valid until ready; ready is a single-cycle completion pulse.
// rdata is only meaningful while ready is high.
interface iomem_tone_bank_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   input  iomem_ready, iomem_rdata);
   modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   output iomem_ready, iomem_rdata);
endinterface

// File: rtl/tone_channel.sv
// One square-wave channel: half-period counter, phase, polarity, optional
// toggle-count auto-stop with sticky done (macro TONE_DURATION_EN).
// Bus writes in the same cycle as a wrap win; tone output is registered.
module tone_channel
   import iomem_tone_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_ctrl,
   input  logic             wr_half,
   input  logic             wr_dur,
   input  logic [3:0]       wstrb,
   input  logic [31:0]      wdata,
   output logic             tone,
   output logic             done,
   output logic [2:0]       ctrl_rd,
   output logic [2:0]       status,
   output logic [CNT_W-1:0] half,
   output logic [CNT_W-1:0] dur
);

   logic             en, en_d, pol, pol_d, phase, phase_d, done_d;
   logic [CNT_W-1:0] cnt, cnt_d, half_d;
   logic             running, wrap, ctrl_wr, restart, stop;
`ifdef TONE_DURATION_EN
   logic [CNT_W-1:0] dur_q, dur_d;
`endif

   assign running = en && (half != '0);
   assign wrap    = running && (cnt == half - CNT_W'(1));
   // CTRL fields all live in byte lane 0.
   assign ctrl_wr = wr_ctrl && wstrb[0];
   assign restart = wr_half || (ctrl_wr && wdata[CTRL_EN] && !en);
   assign stop    = ctrl_wr && !wdata[CTRL_EN];

   // Next state: free-running count, then bus writes override the wrap.
   always_comb begin
      en_d    = en;
      pol_d   = pol;
      half_d  = half;
      done_d  = done;
      cnt_d   = cnt + CNT_W'(1);
      phase_d = phase;
`ifdef TONE_DURATION_EN
      dur_d   = dur_q;
`endif
      if (!running) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (wrap) begin
         cnt_d   = '0;
         phase_d = !phase;
      end
      if (ctrl_wr) begin
         en_d  = wdata[CTRL_EN];
         pol_d = wdata[CTRL_POL];
      end
`ifdef TONE_DURATION_EN
      // Clear first so a same-cycle completion leaves done set.
      if (ctrl_wr && wdata[CTRL_DONE_CLR]) done_d = 1'b0;
      if (wrap && !restart && !stop && (dur_q != '0)) begin
         dur_d = dur_q - CNT_W'(1);
         if (dur_q == CNT_W'(1)) begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            phase_d = 1'b0;
         end
      end
      if (wr_dur) dur_d = CNT_W'(merge_bytes(32'(dur_q), wdata, wstrb));
`endif
      if (wr_half) half_d = CNT_W'(merge_bytes(32'(half), wdata, wstrb));
      if (restart || stop) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end
   end

   // State register; tone is registered from the next phase/polarity.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         en    <= 1'b0;
         pol   <= 1'b0;
         half  <= '0;
         cnt   <= '0;
         phase <= 1'b0;
         done  <= 1'b0;
         tone  <= 1'b0;
      end else begin
         en    <= en_d;
         pol   <= pol_d;
         half  <= half_d;
         cnt   <= cnt_d;
         phase <= phase_d;
         done  <= done_d;
         tone  <= phase_d ^ pol_d;
      end
   end

`ifdef TONE_DURATION_EN
   // Remaining-toggle counter.
   always_ff @(posedge clk) begin
      if (!resetn) dur_q <= '0;
      else         dur_q <= dur_d;
   end
   assign dur = dur_q;
`else
   logic unused_dur;
   assign unused_dur = wr_dur;
   assign dur        = '0;
`endif

   // Readback views of CTRL and STATUS.
   always_comb begin
      ctrl_rd            = '0;
      ctrl_rd[CTRL_EN]   = en;
      ctrl_rd[CTRL_POL]  = pol;
      status             = '0;
      status[STAT_TONE]  = tone;
      status[STAT_RUN]   = running;
      status[STAT_DONE]  = done;
   end

endmodule

// File: rtl/iomem_tone_bank.sv
// NUM_CH-channel square-wave tone generator on the PicoSoC iomem bus.
// One-cycle ack for reads and writes; ready never repeats back-to-back.
// Duration auto-stop and irq_o exist only with macro TONE_DURATION_EN.
module iomem_tone_bank
   import iomem_tone_pkg::*;
#(
   parameter int         NUM_CH  = 4,
   parameter int         CNT_W   = 24,
   parameter logic [7:0] ADDR_HI = 8'h06
) (
   input  logic              clk,
   input  logic              resetn,
   iomem_tone_bank_if.slave  iomem,
   output logic [NUM_CH-1:0] tone_o,
   output logic              irq_o
);

   logic        hit, is_wr, ready_q;
   logic [3:0]  ch;
   reg_e        rsel;
   logic [31:0] rd_val, rdata_q;
   logic [31:0] rd_ctrl [16];
   logic [31:0] rd_half [16];
   logic [31:0] rd_stat [16];
   logic [31:0] rd_dur  [16];
   logic [NUM_CH-1:0] done;
   logic        unused_addr;

   assign hit   = iomem.iomem_valid && !ready_q && (iomem.iomem_addr[31:24] == ADDR_HI);
   assign is_wr = (iomem.iomem_wstrb != 4'b0000);
   assign ch    = iomem.iomem_addr[7:4];
   assign rsel  = reg_e'(iomem.iomem_addr[3:2]);
   assign unused_addr = ^{iomem.iomem_addr[23:8], iomem.iomem_addr[1:0]};

   // Slots beyond NUM_CH read as zero and never receive write strobes.
   for (genvar g = 0; g < 16; g++) begin : g_ch
      if (g < NUM_CH) begin : g_live
         logic             sel, tone, ch_done;
         logic [2:0]       ctrl_rd, status;
         logic [CNT_W-1:0] half, dur;
         assign sel = hit && is_wr && (ch == 4'(g));
         tone_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .wr_ctrl (sel && (rsel == REG_CTRL)),
            .wr_half (sel && (rsel == REG_HALF)),
            .wr_dur  (sel && (rsel == REG_DUR)),
            .wstrb   (iomem.iomem_wstrb),
            .wdata   (iomem.iomem_wdata),
            .tone    (tone),
            .done    (ch_done),
            .ctrl_rd (ctrl_rd),
            .status  (status),
            .half    (half),
            .dur     (dur)
         );
         assign tone_o[g]  = tone;
         assign done[g]    = ch_done;
         assign rd_ctrl[g] = {29'd0, ctrl_rd};
         assign rd_half[g] = 32'(half);
         assign rd_stat[g] = {29'd0, status};
         assign rd_dur[g]  = 32'(dur);
      end else begin : g_none
         assign rd_ctrl[g] = '0;
         assign rd_half[g] = '0;
         assign rd_stat[g] = '0;
         assign rd_dur[g]  = '0;
      end
   end

   // Read data select by register offset.
   always_comb begin
      rd_val = '0;
      case (rsel)
         REG_CTRL:   rd_val = rd_ctrl[ch];
         REG_HALF:   rd_val = rd_half[ch];
         REG_STATUS: rd_val = rd_stat[ch];
         REG_DUR:    rd_val = rd_dur[ch];
         default:    rd_val = '0;
      endcase
   end

   // Ack pulse and captured read data; zero outside an ack.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= hit;
         rdata_q <= (hit && !is_wr) ? rd_val : '0;
      end
   end

   assign iomem.iomem_ready = ready_q;
   assign iomem.iomem_rdata = rdata_q;

`ifdef TONE_DURATION_EN
   logic irq_q;
   // Interrupt is the registered OR of all sticky done flags.
   always_ff @(posedge clk) begin
      if (!resetn) irq_q <= 1'b0;
      else         irq_q <= |done;
   end
   assign irq_o = irq_q;
`else
   logic unused_done;
   assign unused_done = ^done;
   assign irq_o       = 1'b0;
`endif

endmodule
